// File: rtl/fu_arbiter_pkg.sv
// Shared constants for the two-requester functional-unit arbiter.
package fu_arbiter_pkg;

   localparam int unsigned FselW = 4;
   localparam int unsigned FlagW = 4;

   // Bit positions inside the {Z,N,V,C} flag vector.
   localparam int unsigned FlagZ = 3;
   localparam int unsigned FlagN = 2;
   localparam int unsigned FlagV = 1;
   localparam int unsigned FlagC = 0;

   typedef logic [FselW-1:0] fsel_t;
   typedef logic [FlagW-1:0] flags_t;

endpackage

// File: rtl/fu_arbiter_if.sv
// Request, functional-unit and response bundle between the arbiter and its clients.
interface fu_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
);
   import fu_arbiter_pkg::*;

   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*FselW-1:0]  req_fsel;
   logic [2*DATA_W-1:0] req_a;
   logic [2*DATA_W-1:0] req_b;
   logic [1:0]          req_slt;
   logic [1:0]          req_cond;
   logic [2*TAG_W-1:0]  req_tag;

   fsel_t               fu_fsel;
   logic [DATA_W-1:0]   fu_a;
   logic [DATA_W-1:0]   fu_b;
   logic                fu_slt;
   logic                fu_cond;
   logic [DATA_W-1:0]   fu_result;
   flags_t              fu_flags;

   logic                rsp_valid;
   logic                rsp_ready;
   logic                rsp_id;
   logic [TAG_W-1:0]    rsp_tag;
   logic [DATA_W-1:0]   rsp_result;
   flags_t              rsp_flags;

   // Arbiter side.
   modport slave (
      input  req_valid, req_fsel, req_a, req_b, req_slt, req_cond, req_tag,
      output req_ready,
      output fu_fsel, fu_a, fu_b, fu_slt, fu_cond,
      input  fu_result, fu_flags,
      output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags,
      input  rsp_ready
   );

   // Requesters, functional unit and response sink.
   modport master (
      output req_valid, req_fsel, req_a, req_b, req_slt, req_cond, req_tag,
      input  req_ready,
      input  fu_fsel, fu_a, fu_b, fu_slt, fu_cond,
      output fu_result, fu_flags,
      input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_flags,
      output rsp_ready
   );

endinterface

// File: rtl/fu_rr_arb.sv
// Two-way round-robin grant with its preference pointer register.
module fu_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic       can_accept,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic ptr_q, ptr_d;

   always_comb begin
      grant     = 2'b00;
      grant_idx = 1'b0;
      unique case (req_valid)
         2'b01: begin
            grant     = 2'b01;
            grant_idx = 1'b0;
         end
         2'b10: begin
            grant     = 2'b10;
            grant_idx = 1'b1;
         end
         2'b11: begin
            grant     = ptr_q ? 2'b10 : 2'b01;
            grant_idx = ptr_q;
         end
         default: begin
            grant     = 2'b00;
            grant_idx = 1'b0;
         end
      endcase
   end

   // An accept hands preference to the requester that just lost (or was idle).
   always_comb begin
      ptr_d = ptr_q;
      if (can_accept && (|req_valid)) begin
         ptr_d = ~grant_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/fu_arbiter.sv
// Shares one functional unit between two requesters with a one-entry response buffer.
// Define FU_ARBITER_FLAGS_EN to register fu_flags into rsp_flags; otherwise rsp_flags is 0.
module fu_arbiter
   import fu_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   fu_arbiter_if.slave  bus
);

   logic [1:0] grant;
   logic       grant_idx;
   logic       can_accept;
   logic       accept;

   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;

   assign can_accept = !rsp_valid_q || bus.rsp_ready;
   assign accept     = can_accept && (|grant);

   fu_rr_arb u_rr_arb (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (bus.req_valid),
      .can_accept (can_accept),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   always_comb begin
      bus.req_ready = can_accept ? grant : 2'b00;
   end

   // Operand mux; everything is held at zero when nobody is granted.
   always_comb begin
      bus.fu_fsel = '0;
      bus.fu_a    = '0;
      bus.fu_b    = '0;
      bus.fu_slt  = 1'b0;
      bus.fu_cond = 1'b0;
      if (|grant) begin
         if (grant_idx) begin
            bus.fu_fsel = bus.req_fsel[2*FselW-1:FselW];
            bus.fu_a    = bus.req_a[2*DATA_W-1:DATA_W];
            bus.fu_b    = bus.req_b[2*DATA_W-1:DATA_W];
            bus.fu_slt  = bus.req_slt[1];
            bus.fu_cond = bus.req_cond[1];
         end else begin
            bus.fu_fsel = bus.req_fsel[FselW-1:0];
            bus.fu_a    = bus.req_a[DATA_W-1:0];
            bus.fu_b    = bus.req_b[DATA_W-1:0];
            bus.fu_slt  = bus.req_slt[0];
            bus.fu_cond = bus.req_cond[0];
         end
      end
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_result_d = rsp_result_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant_idx;
         rsp_tag_d    = grant_idx ? bus.req_tag[2*TAG_W-1:TAG_W] : bus.req_tag[TAG_W-1:0];
         rsp_result_d = bus.fu_result;
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_result_q <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_result_q <= rsp_result_d;
      end
   end

`ifdef FU_ARBITER_FLAGS_EN
   flags_t rsp_flags_q, rsp_flags_d;

   always_comb begin
      rsp_flags_d = rsp_flags_q;
      if (accept) begin
         rsp_flags_d = bus.fu_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_flags_q <= '0;
      end else begin
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign bus.rsp_flags = rsp_flags_q;
`else
   assign bus.rsp_flags = '0;
`endif

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_tag    = rsp_tag_q;
   assign bus.rsp_result = rsp_result_q;

endmodule

// File: doc/fu_arbiter.md
FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width (the functional unit is 32-bit).
REQ-002 SHALL have parameter TAG_W, default 4, width of the opaque per-request tag.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  2  per-requester request valid (bit i = requester i).
REQ-006 req_ready  out  2  per-requester accept; at most one bit high.
REQ-007 req_fsel  in  8  function select, 4 bits per requester, [4i+3:4i].
REQ-008 req_a, req_b  in  2*DATA_W each  operands, [DATA_W*i +: DATA_W].
REQ-009 req_slt, req_cond  in  2 each  set-less-than select and precomputed condition bit.
REQ-010 req_tag  in  2*TAG_W  tag returned unchanged with the response.
REQ-011 fu_fsel  out  4; fu_a, fu_b  out  DATA_W; fu_slt, fu_cond  out  1: functional-unit operand drive.
REQ-012 fu_result  in  DATA_W; fu_flags  in  4 {Z,N,V,C}: functional-unit outputs (combinational path).
REQ-013 rsp_valid  out  1; rsp_ready  in  1: response handshake.
REQ-014 rsp_id  out  1; rsp_tag  out  TAG_W; rsp_result  out  DATA_W; rsp_flags  out  4: response payload.

Function
REQ-015 SHALL share one functional unit between two requesters; a request is accepted in the cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 can_accept = !rsp_valid || rsp_ready; req_ready[i] SHALL equal can_accept && grant[i].
REQ-017 Grant: one valid requester -> that requester; both valid -> requester named by round-robin pointer; none valid -> no grant.
REQ-018 Pointer SHALL update only on accept, to the non-granted requester; it SHALL hold otherwise.
REQ-019 fu_* SHALL be driven combinationally from the granted requester's fields; with no grant they SHALL be all zero.
REQ-020 On accept, fu_result, fu_flags, granted index and tag SHALL be registered into the response buffer; rsp_valid rises the next cycle (latency 1).
REQ-021 While rsp_valid && !rsp_ready, req_ready SHALL be 0 and all rsp_* SHALL hold stable.
REQ-022 rsp_ready high in the same cycle as a new accept SHALL overwrite the buffer with no bubble (throughput 1/cycle).
REQ-023 rsp_valid SHALL fall the cycle after rsp_ready with no accept.

Reset
REQ-024 On rst_n low, asynchronously: rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, rsp_flags=0, pointer=0 (requester 0 preferred).
REQ-025 Reset mid-operation SHALL discard any buffered response; no response issues after release without a new accept.

Configuration
REQ-026 Macro FU_ARBITER_FLAGS_EN: defined -> rsp_flags carries registered fu_flags; undefined -> rsp_flags tied to 4'b0 and no flag storage is built.

Structure
REQ-027 Shared package SHALL hold the flag bit-index constants (Z=3,N=2,V=1,C=0) and the 4-bit function-select width constant.
REQ-028 One sub-module, fu_rr_arb (2-way round-robin grant plus pointer register), SHALL be used; the response buffer stays in fu_arbiter.

Verification
REQ-029 Only req_valid=2'b01, A=5, B=3, fsel=ADD, rsp_ready=1 -> req_ready=2'b01, next cycle rsp_valid=1, rsp_id=0, rsp_result=8.
REQ-030 Both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1 back-to-back.
REQ-031 rsp_ready=0 for 3 cycles after a response -> req_ready=2'b00 and rsp_result/rsp_tag unchanged for 3 cycles; drain on rsp_ready=1.
REQ-032 req1 SLT with req_cond=1, A=7 -> rsp_result=32'h1, rsp_tag equals req1's tag.
REQ-033 rst_n low while rsp_valid=1 -> rsp_valid=0 immediately, pointer=0; next dual request grants requester 0.
REQ-034 With and without FU_ARBITER_FLAGS_EN: A=B=32'h5, SUB -> rsp_flags=4'b1000 (Z) with macro, 4'b0000 without.
